mux_arb_rr: RTL and testbench

MUX_ARB_RR -- requirements
Module: mux_arb_rr

---
 rtl/mux_pkg.sv | 10 +
 rtl/rr_pick.sv | 35 +++
 rtl/mux_arb_rr.sv | 90 +++++++++
 tb/tb_mux_arb_rr.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and types for the round-robin arbitrating multiplexer.
package mux_pkg;

  localparam int SEL_WIDTH_DEF = 2;
  localparam int DAT_WIDTH_DEF = 8;

  // Select index at the default requester count.
  typedef logic [SEL_WIDTH_DEF-1:0] sel_t;

endpackage : mux_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin search: the first requester at or above ptr_i,
// wrapping from N-1 to 0, wins. Returns a one-hot grant and its index.
module rr_pick
  import mux_pkg::*;
#(
  parameter int SEL_WIDTH = SEL_WIDTH_DEF,
  localparam int N = 2 ** SEL_WIDTH
) (
  input  logic [N-1:0]         req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [SEL_WIDTH-1:0] idx_o,
  output logic                 any_o
);

  logic [SEL_WIDTH-1:0] cand;

  // Walk the N positions starting at ptr_i; modulo-N wrap falls out of the
  // SEL_WIDTH-bit addition, so no extra cycle or special case is needed.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_i + SEL_WIDTH'(i);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/mux_arb_rr.sv
// Round-robin arbitrating multiplexer with a one-entry registered output.
//
// Handshake: the output word (dat_o, sel_o) is offered while vld_o = 1 and is
// taken on a rising edge where vld_o and rdy_i are both 1. vld_o never drops
// while the word is waiting, and the word is stable until taken. On the input
// side gnt_o[k] = 1 means requester k's word is captured on the next edge;
// a requester keeps req_i/dat_i steady until it sees its grant.
module mux_arb_rr
  import mux_pkg::*;
#(
  parameter int SEL_WIDTH = SEL_WIDTH_DEF,
  parameter int DAT_WIDTH = DAT_WIDTH_DEF,
  localparam int N = 2 ** SEL_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [N-1:0]                req_i,
  input  logic [N-1:0][DAT_WIDTH-1:0] dat_i,
  output logic [N-1:0]                gnt_o,
  output logic                        vld_o,
  output logic [DAT_WIDTH-1:0]        dat_o,
  output logic [SEL_WIDTH-1:0]        sel_o,
  input  logic                        rdy_i
);

  logic                 vld_q, vld_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

  logic                 reg_open;
  logic [N-1:0]         pick_gnt;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 pick_any;

  rr_pick #(
    .SEL_WIDTH(SEL_WIDTH)
  ) u_pick (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  // The register can accept a new word when empty or when its word leaves now.
  assign reg_open = !vld_q || rdy_i;

  // Grant is gated by the register being open; reset forces it low so nothing
  // upstream believes a word was taken while the register is being cleared.
  assign gnt_o = (reg_open && rst_n_i) ? pick_gnt : '0;

  // Next-state: load the winner, drain to empty, or hold while stalled.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    if (reg_open) begin
      if (pick_any) begin
        vld_d = 1'b1;
        dat_d = dat_i[pick_idx];
        sel_d = pick_idx;
        ptr_d = pick_idx + 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer; reset discards any held word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;
  assign sel_o = sel_q;

endmodule : mux_arb_rr

// File: tb/tb_mux_arb_rr.sv
// Bench for mux_arb_rr: directed vectors, a behavioural model checked every
// cycle, an expected-word queue for the output stream, and literal pins.
module tb_mux_arb_rr;

  localparam int SW = 2;
  localparam int DW = 8;
  localparam int N  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic               clk   = 1'b0;
  logic               rst_n = 1'b1;
  logic [N-1:0]       req   = '0;
  logic [N-1:0][DW-1:0] dat = '0;
  logic               rdy   = 1'b0;
  logic [N-1:0]       gnt;
  logic               vld;
  logic [DW-1:0]      dout;
  logic [SW-1:0]      sel;

  always #5 clk = ~clk;

  mux_arb_rr #(.SEL_WIDTH(SW), .DAT_WIDTH(DW)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .req_i  (req),
    .dat_i  (dat),
    .gnt_o  (gnt),
    .vld_o  (vld),
    .dat_o  (dout),
    .sel_o  (sel),
    .rdy_i  (rdy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Register contents and pointer as the rules describe them, in plain ints.
  int          m_vld = 0;
  int          m_dat = 0;
  int          m_sel = 0;
  int          m_ptr = 0;
  logic [SW+DW-1:0] exp_q[$];

  // Winner from the rules: first requesting index scanning up from p, wrapping.
  function automatic int winner(input logic [N-1:0] r, input int p);
    for (int off = 0; off < N; off++) begin
      if (r[(p + off) % N]) return (p + off) % N;
    end
    return -1;
  endfunction

  function automatic int exp_gnt();
    int w;
    w = winner(req, m_ptr);
    if (!rst_n) return 0;
    if (m_vld != 0 && !rdy) return 0;
    if (w < 0) return 0;
    return 1 << w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_vld = 0; m_dat = 0; m_sel = 0; m_ptr = 0;
      exp_q.delete();
    end else if (m_vld == 0 || rdy) begin
      w = winner(req, m_ptr);
      if (w >= 0) begin
        m_vld = 1;
        m_dat = int'(dat[w]);
        m_sel = w;
        m_ptr = (w + 1) % N;
        exp_q.push_back({SW'(w), dat[w]});
      end else begin
        m_vld = 0;
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  logic [SW+DW-1:0] front;
  always @(negedge clk) begin
    check("gnt_model", 32'(gnt), 32'(exp_gnt()));
    check("vld_model", 32'(vld), 32'(m_vld));
    check("dat_model", 32'(dout), 32'(m_dat));
    check("sel_model", 32'(sel), 32'(m_sel));
    if (vld === 1'b1 && rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", 32'({sel, dout}), 32'hFFFF_FFFF);
      end else begin
        front = exp_q.pop_front();
        check("sb_word", 32'({sel, dout}), 32'(front));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] r, input logic rd);
    @(posedge clk);
    #1;
    req = r;
    rdy = rd;
  endtask

  // Mixed tail vectors: drops before grant, stalls, wrap, idle.
  logic [N-1:0] tail_req[12] = '{4'b0100, 4'b0100, 4'b0000, 4'b1001, 4'b1001, 4'b1001,
                                 4'b0110, 4'b0000, 4'b1111, 4'b1111, 4'b0001, 4'b0000};
  logic         tail_rdy[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  // ---------------- stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Idle after reset: nothing granted, nothing valid, data zero.
    drive(4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_vld", 32'(vld), 32'h0);
      check("idle_dat", 32'(dout), 32'h0);
    end

    // All requesting, sink always ready: strict rotation, one word per cycle.
    for (int k = 0; k < N; k++) dat[k] = 8'hA0 + 8'(k);
    drive(4'b1111, 1'b1);
    @(negedge clk);
    check("rot_first_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rot_vld", 32'(vld), 32'h1);
      check("rot_sel", 32'(sel), 32'(i % 4));
      check("rot_dat", 32'(dout), 32'(8'hA0 + 8'(i % 4)));
    end

    // Only requester 3: granted every cycle, pointer wraps to 0 each time.
    drive(4'b1000, 1'b1);
    @(negedge clk);
    check("solo_gnt0", 32'(gnt), 32'h8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("solo_gnt", 32'(gnt), 32'h8);
      check("solo_sel", 32'(sel), 32'h3);
      check("solo_dat", 32'(dout), 32'hA3);
    end

    // Stall with requesters 0 and 1 waiting: everything holds.
    dat[0] = 8'hB0;
    dat[1] = 8'hB1;
    drive(4'b0011, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_gnt", 32'(gnt), 32'h0);
      check("stall_vld", 32'(vld), 32'h1);
      check("stall_sel", 32'(sel), 32'h3);
      check("stall_dat", 32'(dout), 32'hA3);
    end
    // Ready returns: grant resumes at the pointer (0), back-to-back.
    drive(4'b0011, 1'b1);
    @(negedge clk);
    check("resume_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    check("resume_sel0", 32'(sel), 32'h0);
    check("resume_dat0", 32'(dout), 32'hB0);
    check("resume_gnt1", 32'(gnt), 32'h2);
    @(negedge clk);
    check("resume_sel1", 32'(sel), 32'h1);
    check("resume_dat1", 32'(dout), 32'hB1);
    check("resume_vld1", 32'(vld), 32'h1);
    check("resume_gnt2", 32'(gnt), 32'h1);

    // Reset mid-stream: outputs clear before the next clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_vld", 32'(vld), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_dat", 32'(dout), 32'h0);
    check("rst_gnt", 32'(gnt), 32'h0);
    req = 4'b0110;
    dat[1] = 8'hC1;
    dat[2] = 8'hC2;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    check("post_rst_sel", 32'(sel), 32'h1);
    check("post_rst_dat", 32'(dout), 32'hC1);
    check("post_rst_gnt2", 32'(gnt), 32'h4);

    // Mixed tail, checked by the model only.
    for (int k = 0; k < N; k++) dat[k] = 8'hD0 + 8'(k);
    for (int i = 0; i < 12; i++) drive(tail_req[i], tail_rdy[i]);
    drive(4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    check("final_vld", 32'(vld), 32'h0);
    check("final_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_arb_rr
